sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
- Parametrised asynchronous-SRAM controller for the CPU memory path (base/ext RAM on the board).
- Converts a single-cycle valid/ready request from the memory stage into a timed SRAM cycle: setup, programmable access wait, hold.
- Handles byte-lane writes, a registered read return, a done pulse, and tristate control of the shared data bus.

Parameters:
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, data bus width; must be a multiple of 8
- WAIT_CYCLES, 1, ACCESS-state length in cycles (WE_n low / OE_n low); legal range 1..15

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- req_i  in  1  request valid; accepted on an edge where req_i && ready_o
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_W  word address
- wdata_i  in  DATA_W  write data
- be_i  in  DATA_W/8  byte enables for writes, active-high
- ready_o  out  1  controller idle, can accept
- ack_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_W  read data, valid from ack_o onward
- sram_addr_o  out  ADDR_W  SRAM address
- sram_data_io  inout  DATA_W  SRAM data bus
- sram_ce_n_o  out  1  chip enable, active-low
- sram_oe_n_o  out  1  output enable, active-low
- sram_we_n_o  out  1  write enable, active-low
- sram_be_n_o  out  DATA_W/8  byte enables, active-low

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, ready_o=1, ack_o=0, rdata_o=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_be_n_o=all 1, sram_addr_o=0, data bus high-Z.
  - Reset mid-operation aborts immediately: strobes rise asynchronously, no ack is issued, the latched request is discarded.
- Acceptance:
  - addr/we/wdata/be are latched at the accepting edge; later input changes are ignored.
  - req_i while ready_o=0 is ignored; the requester holds req_i until accepted.
- FSM IDLE -> SETUP -> ACCESS -> HOLD -> IDLE:
  - IDLE: ready_o=1; all strobes high; bus high-Z.
  - SETUP (1 cycle): sram_addr_o=latched addr; ce_n=0; oe_n=1; we_n=1. On a write the bus drives wdata and be_n=~be. On a read be_n=all 0.
  - ACCESS (WAIT_CYCLES cycles, down-counter): a write holds we_n=0 with data driven; a read holds oe_n=0 with the bus high-Z. On the last ACCESS edge a read captures sram_data_io into rdata_o.
  - HOLD (1 cycle): we_n=1, oe_n=1, ce_n=0, addr held. On a write, data remains driven (hold time). ack_o=1 for exactly this cycle.
- Latency and throughput:
  - Request accepted at edge E0 -> ack_o high from E(WAIT_CYCLES+1) to E(WAIT_CYCLES+2).
  - ready_o is 0 from the cycle after E0 until IDLE is re-entered.
  - Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- Data bus and read data:
  - The FPGA drives sram_data_io only during write SETUP/ACCESS/HOLD; otherwise high-Z. It never drives while oe_n=0.
  - rdata_o holds its value until the next read capture; writes do not alter it.
- Boundary cases:
  - be_i=0 on a write runs a full cycle with be_n all 1 (no bytes change) and still acks.
  - addr_i all-ones is legal; there is no wrap logic because addresses are not incremented.

Optional Feature:
- Macro SRAM_CTRL_TURNAROUND_EN.
- Defined: when a write is accepted and the previous completed access was a read, insert one TURN cycle before SETUP. In TURN, ce_n=1, oe_n=1, we_n=1 and the bus is high-Z, so the SRAM releases the bus before the FPGA drives it. Ack latency for that write grows by 1. A "last was read" flag is cleared by reset.
- Undefined: no TURN state; latency is always WAIT_CYCLES+2.

Decomposition:
- Package sram_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD, TURN)
  - localparam BE_W = DATA_W/8
  - wait-counter width of 4 bits
- One sub-module, sram_data_iobuf: tristate buffer with drive_en, out-data and in-data; isolates the inout for synthesis and simulation.
- FSM, counter and registers stay in sram_ctrl.

Test Plan:
- Reset: hold rst=0 mid-ACCESS of a write -> we_n=1, ce_n=1 and bus high-Z asynchronously; no ack_o; ready_o=1 after release.
- Word write then read, WAIT_CYCLES=1:
  - Write 0xBEEF @0x00012, be=2'b11 -> we_n low for exactly 1 cycle, ack_o at E2.
  - Read @0x00012 -> rdata_o=0xBEEF with ack_o at E2.
- Byte lanes: write 0x1234 @0x3FFFF, then write 0xAB00 with be=2'b10 -> read returns 0xAB34; also exercises top address.
- WAIT_CYCLES=3: read -> oe_n low for 3 cycles, ack_o at E4, ready_o low for 5 cycles; back-to-back requests accepted every 6 cycles.
- Protocol checker on every cycle:
  - req_i pulsed while ready_o=0 -> ignored, no extra ack.
  - Bus never driven while oe_n=0.
  - ack_o is never 2 consecutive cycles.
- Turnaround, with SRAM_CTRL_TURNAROUND_EN: read then write -> one cycle with all strobes high between read HOLD and write SETUP; write ack latency is 4 with WAIT_CYCLES=1. Without the macro, latency is 3.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_pkg: FSM state encoding and widths shared by the sram_ctrl files
package sram_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURN} state_t;
    localparam int CNT_W = 4;
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/sram_data_iobuf.sv
// sram_data_iobuf: tristate driver that isolates the shared SRAM data bus
module sram_data_iobuf #(
    parameter int W = 16
) (
    input  logic         drive_en_i,
    input  logic [W-1:0] out_data_i,
    output logic [W-1:0] in_data_o,
    inout  wire  [W-1:0] pad_io
);
    assign pad_io    = drive_en_i ? out_data_i : {W{1'bz}};
    assign in_data_o = pad_io;
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: async SRAM controller (setup / timed access / hold) with byte lanes.
// Define SRAM_CTRL_TURNAROUND_EN to insert a bus-release cycle before a write that follows a read.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic [be_width(DATA_W)-1:0] be_i,
    output logic                        ready_o,
    output logic                        ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [ADDR_W-1:0]           sram_addr_o,
    inout  wire  [DATA_W-1:0]           sram_data_io,
    output logic                        sram_ce_n_o,
    output logic                        sram_oe_n_o,
    output logic                        sram_we_n_o,
    output logic [be_width(DATA_W)-1:0] sram_be_n_o
);
    localparam int BE_W = be_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q, drive_q, ready_q, ack_q, ce_n_q, oe_n_q, we_n_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q, bus_in;
    logic [BE_W-1:0]     be_n_q;
    logic                go_turn;

`ifdef SRAM_CTRL_TURNAROUND_EN
    logic            last_rd_q;
    logic [BE_W-1:0] be_q;
    assign go_turn = we_i && last_rd_q;
`else
    assign go_turn = 1'b0;
`endif

    sram_data_iobuf #(.W(DATA_W)) u_iobuf (
        .drive_en_i (drive_q),
        .out_data_i (wdata_q),
        .in_data_o  (bus_in),
        .pad_io     (sram_data_io)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            drive_q <= 1'b0;
`ifdef SRAM_CTRL_TURNAROUND_EN
            last_rd_q <= 1'b0;
            be_q      <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: if (req_i) begin
                    state_q <= go_turn ? TURN : SETUP;
                    we_q    <= we_i;
                    addr_q  <= addr_i;
                    wdata_q <= wdata_i;
                    ready_q <= 1'b0;
                    ce_n_q  <= go_turn;
                    be_n_q  <= go_turn ? '1 : (we_i ? ~be_i : '0);
                    drive_q <= we_i && !go_turn;
`ifdef SRAM_CTRL_TURNAROUND_EN
                    be_q    <= be_i;
`endif
                end
`ifdef SRAM_CTRL_TURNAROUND_EN
                // SRAM has released the bus by now; start the write setup
                TURN: begin
                    state_q <= SETUP;
                    ce_n_q  <= 1'b0;
                    be_n_q  <= ~be_q;
                    drive_q <= 1'b1;
                end
`endif
                SETUP: begin
                    state_q <= ACCESS;
                    cnt_q   <= LAST_CNT;
                    we_n_q  <= !we_q;
                    oe_n_q  <= we_q;
                end
                ACCESS: if (cnt_q == '0) begin
                    state_q <= HOLD;
                    we_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    ack_q   <= 1'b1;
                    if (!we_q) rdata_q <= bus_in;
`ifdef SRAM_CTRL_TURNAROUND_EN
                    last_rd_q <= !we_q;
`endif
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                HOLD: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    ce_n_q  <= 1'b1;
                    be_n_q  <= '1;
                    drive_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;
    assign sram_be_n_o = be_n_q;
endmodule
